ide_dma_ctrl: RTL

IDE_DMA_CTRL -- requirements
Module: ide_dma_ctrl

---
 rtl/ide_dma_pkg.sv | 17 +
 rtl/ide_dma_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ide_dma_pkg.sv
// rtl/ide_dma_pkg.sv - shared definitions for the IDE DMA controller
//
// Holds the controller state encoding and the default address/count widths
// so the controller and anything that instantiates it agree on them.
package ide_dma_pkg;

  localparam int ADDR_W_DEF = 21;  // word-address width
  localparam int CNT_W_DEF  = 8;   // word-count width; a count of 0 means 2^CNT_W

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_RD   = 2'd1,
    IDE_XFER = 2'd2,
    MEM_WR   = 2'd3
  } state_t;

endpackage

// File: rtl/ide_dma_ctrl.sv
// rtl/ide_dma_ctrl.sv - word-at-a-time DMA engine between an IDE port and memory
//
// Moves a burst of 16-bit words between memory and the IDE data port, one
// word at a time.
//   IDE -> memory (dir_rd=1): IDE_XFER -> MEM_WR per word.
//   memory -> IDE (dir_rd=0): MEM_RD -> IDE_XFER per word.
//
// Ports:
//   clk, reset_n       clock; asynchronous active-low reset
//   start              one-cycle burst request (ignored while busy)
//   dir_rd             1 = IDE->memory, 0 = memory->IDE
//   addr_in, cnt_in    first word address and word count (0 = 2^CNT_W words)
//   abort              one-cycle stop request, honoured at the next word boundary
//   busy               burst in progress
//   done               one-cycle end-of-burst pulse
//   aborted            last burst was ended by abort
//   remaining          words still to move
//   dma_req, dma_rnw   IDE cycle request and direction
//   dma_out            write data to IDE
//   ide_in             read data from IDE
//   ide_rdy_stb        IDE cycle-complete strobe
//   mem_req, mem_rnw   memory request and direction
//   mem_addr           memory word address
//   mem_wdata          memory write data
//   mem_rdata          memory read data
//   mem_ack            one-cycle memory completion
//
// Every output comes straight from a flop. The request/direction flops are
// loaded from the next-state value, so they change together with the state.
module ide_dma_ctrl
  import ide_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              dir_rd,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  remaining,
  output logic              dma_req,
  output logic              dma_rnw,
  output logic [15:0]       dma_out,
  input  logic [15:0]       ide_in,
  input  logic              ide_rdy_stb,
  output logic              mem_req,
  output logic              mem_rnw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_r, addr_n;
  logic [CNT_W-1:0]  cnt_r, cnt_n;
  logic [15:0]       data_r, data_n;
  logic              dir_r, dir_n;
  logic              abort_pend, abort_pend_n;
  logic              aborted_n, done_n;
  logic              busy_n, dma_req_n, dma_rnw_n, mem_req_n, mem_rnw_n;
  logic              word_done;
  logic              abort_now;
  logic              last_word;

  always_comb begin
    state_n      = state;
    addr_n       = addr_r;
    cnt_n        = cnt_r;
    data_n       = data_r;
    dir_n        = dir_r;
    abort_pend_n = abort_pend;
    aborted_n    = aborted;
    done_n       = 1'b0;
    word_done    = 1'b0;
    last_word    = (cnt_r == CNT_W'(1));

    // An abort arriving in the same cycle as a word completes counts as
    // pending for that boundary.
    abort_now = abort_pend | (busy & abort);
    if (busy && abort) begin
      abort_pend_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (start) begin
          addr_n       = addr_in;
          cnt_n        = cnt_in;
          dir_n        = dir_rd;
          aborted_n    = 1'b0;
          abort_pend_n = 1'b0;
          state_n      = dir_rd ? IDE_XFER : MEM_RD;
        end
      end
      MEM_RD: begin
        if (mem_ack) begin
          data_n  = mem_rdata;
          state_n = IDE_XFER;
        end
      end
      IDE_XFER: begin
        if (ide_rdy_stb) begin
          if (dir_r) begin
            data_n  = ide_in;
            state_n = MEM_WR;
          end else begin
            word_done = 1'b1;
          end
        end
      end
      MEM_WR: begin
        if (mem_ack) begin
          word_done = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (word_done) begin
      addr_n = addr_r + ADDR_W'(1);
      cnt_n  = cnt_r - CNT_W'(1);
      if (last_word || abort_now) begin
        state_n      = IDLE;
        done_n       = 1'b1;
        // Finishing the final word is a normal end even if abort coincides.
        aborted_n    = abort_now && !last_word;
        abort_pend_n = 1'b0;
      end else begin
        state_n = dir_r ? IDE_XFER : MEM_RD;
      end
    end

    busy_n    = (state_n != IDLE);
    dma_req_n = (state_n == IDE_XFER);
    mem_req_n = (state_n == MEM_RD) || (state_n == MEM_WR);
    mem_rnw_n = (state_n != MEM_WR);
    dma_rnw_n = (state_n == IDLE) ? 1'b1 : dir_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr_r     <= '0;
      cnt_r      <= '0;
      data_r     <= '0;
      dir_r      <= 1'b0;
      abort_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      dma_req    <= 1'b0;
      dma_rnw    <= 1'b1;
      mem_req    <= 1'b0;
      mem_rnw    <= 1'b1;
    end else begin
      state      <= state_n;
      addr_r     <= addr_n;
      cnt_r      <= cnt_n;
      data_r     <= data_n;
      dir_r      <= dir_n;
      abort_pend <= abort_pend_n;
      busy       <= busy_n;
      done       <= done_n;
      aborted    <= aborted_n;
      dma_req    <= dma_req_n;
      dma_rnw    <= dma_rnw_n;
      mem_req    <= mem_req_n;
      mem_rnw    <= mem_rnw_n;
    end
  end

  assign remaining = cnt_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = data_r;
  assign dma_out   = data_r;

endmodule
